// File: rtl/ds1302_if.sv
// DS1302 3-wire master: periodic clock-burst read of sec/min/hour plus
// single-register writes. Bits are sent and received LSB first, one bit per SCLK cell.
module ds1302_if #(
    parameter int unsigned CLK_DIV     = 50,
    parameter int unsigned CE_SETUP    = 200,
    parameter int unsigned POLL_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       busy,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       time_valid,
    output logic       time_upd,
    output logic       ds_ce,
    output logic       ds_sclk,
    output logic       ds_io_out,
    output logic       ds_io_oe,
    input  logic       ds_io_in
);

    localparam int unsigned CNT_MAX = (CE_SETUP > CLK_DIV) ? CE_SETUP : CLK_DIV;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned PW      = $clog2(POLL_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SETUP, CMD, WDATA, RDATA, HOLD, GAP, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      bit_q, bit_d;
    logic            sclk_q, sclk_d;
    logic            ce_q, ce_d;
    logic            oe_q, oe_d;
    logic            wr_q, wr_d;
    logic [15:0]     tx_q, tx_d;
    logic [23:0]     rx_q, rx_d;
    logic [7:0]      sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic            valid_q, valid_d;
    logic            upd_q, upd_d;
    logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
    logic            poll_q, poll_d;
    logic            sync1_q, sync2_q;
    logic            poll_hit;

    assign poll_hit = (poll_cnt_q == PW'(POLL_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sclk_d     = sclk_q;
        ce_d       = ce_q;
        oe_d       = oe_q;
        wr_d       = wr_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        valid_d    = valid_q;
        upd_d      = 1'b0;
        poll_d     = poll_q;
        poll_cnt_d = poll_hit ? '0 : poll_cnt_q + PW'(1);

        case (state_q)
            IDLE: begin
                if (wr_req || poll_q) begin
                    state_d = SETUP;
                    cnt_d   = CW'(CE_SETUP - 1);
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    sclk_d  = 1'b0;
                    wr_d    = wr_req;
                    if (wr_req) begin
                        tx_d = {wr_data, 2'b10, wr_addr, 1'b0};
                    end else begin
                        tx_d   = {8'h00, 8'hBF};
                        poll_d = 1'b0;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = CMD;
                    cnt_d   = CW'(CLK_DIV - 1);
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CMD, WDATA, RDATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = CW'(CLK_DIV - 1);
                    if (!sclk_q) begin
                        // last clk of the low phase: sample the slave's bit
                        sclk_d = 1'b1;
                        if (state_q == RDATA) rx_d = {sync2_q, rx_q[23:1]};
                    end else begin
                        sclk_d = 1'b0;
                        tx_d   = {1'b0, tx_q[15:1]};
                        bit_d  = bit_q + 5'd1;
                        if (state_q == CMD && bit_q == 5'd7) begin
                            state_d = wr_q ? WDATA : RDATA;
                            oe_d    = wr_q;
                        end
                        if ((state_q == WDATA && bit_q == 5'd15) ||
                            (state_q == RDATA && bit_q == 5'd31)) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CW'(CE_SETUP - 1);
                    ce_d    = 1'b0;
                    oe_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            DONE: begin
                state_d = IDLE;
                if (!wr_q) begin
                    sec_d   = rx_q[7:0] & 8'h7F;
                    min_d   = rx_q[15:8];
                    hour_d  = rx_q[23:16] & 8'h3F;
                    valid_d = 1'b1;
                    upd_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (poll_hit) poll_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sclk_q     <= 1'b0;
            ce_q       <= 1'b0;
            oe_q       <= 1'b0;
            wr_q       <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            valid_q    <= 1'b0;
            upd_q      <= 1'b0;
            poll_cnt_q <= '0;
            poll_q     <= 1'b1;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            ce_q       <= ce_d;
            oe_q       <= oe_d;
            wr_q       <= wr_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            valid_q    <= valid_d;
            upd_q      <= upd_d;
            poll_cnt_q <= poll_cnt_d;
            poll_q     <= poll_d;
            sync1_q    <= ds_io_in;
            sync2_q    <= sync1_q;
        end
    end

    assign ds_ce      = ce_q;
    assign ds_sclk    = sclk_q;
    assign ds_io_out  = tx_q[0];
    assign ds_io_oe   = oe_q;
    assign busy       = (state_q != IDLE);
    assign wr_ack     = (state_q == DONE) && wr_q;
    assign time_upd   = upd_q;
    assign time_valid = valid_q;
    assign sec_bcd    = sec_q;
    assign min_bcd    = min_q;
    assign hour_bcd   = hour_q;

endmodule

// File: tb/tb_ds1302_if.sv
// Directed bench for ds1302_if with a behavioural DS1302 slave and
// queue-based scoreboards for bus bytes and decoded time.
module tb_ds1302_if;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned CE_SETUP = 8;
    localparam int unsigned POLL     = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_req = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ack, busy, time_valid, time_upd;
    logic [7:0] sec_bcd, min_bcd, hour_bcd;
    logic       ds_ce, ds_sclk, ds_io_out, ds_io_oe, ds_io_in;

    always #5 clk = ~clk;

    ds1302_if #(.CLK_DIV(CLK_DIV), .CE_SETUP(CE_SETUP), .POLL_CYCLES(POLL)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .busy(busy), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
        .hour_bcd(hour_bcd), .time_valid(time_valid), .time_upd(time_upd),
        .ds_ce(ds_ce), .ds_sclk(ds_sclk), .ds_io_out(ds_io_out), .ds_io_oe(ds_io_oe),
        .ds_io_in(ds_io_in)
    );

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];   // {hour, min, sec}
    logic [7:0]  bus_q[$];   // expected write command/data bytes
    int unsigned cyc = 0;
    int unsigned ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pop_bus();
        if (bus_q.size() == 0) return 8'hxx;
        return bus_q.pop_front();
    endfunction

    // behavioural DS1302: samples on SCLK rise, drives burst data on SCLK fall
    logic [7:0]  mregs [8];
    int unsigned mbit = 0;
    int unsigned ridx = 0;
    logic [7:0]  msh = '0;
    logic [7:0]  mcmd = '0;
    logic        mread = 1'b0;
    logic        moe_ok = 1'b1;
    logic        mio = 1'b0;
    assign ds_io_in = mio;

    always @(posedge ds_sclk or negedge ds_ce) begin
        if (ds_ce !== 1'b1) begin
            mbit = 0;
            mread = 1'b0;
            moe_ok = 1'b1;
        end else if (!mread) begin
            msh = {ds_io_out, msh[7:1]};
            if (ds_io_oe !== 1'b1) moe_ok = 1'b0;
            mbit++;
            if (mbit == 8) begin
                mcmd = msh;
                chk("oe_cmd_bits", moe_ok, 1);
                moe_ok = 1'b1;
                if (mcmd[0]) begin
                    chk("read_cmd", mcmd, 8'hBF);
                    mread = 1'b1;
                    ridx = 0;
                end else begin
                    chk("write_cmd", mcmd, pop_bus());
                end
            end else if (mbit == 16) begin
                chk("oe_data_bits", moe_ok, 1);
                chk("write_data", msh, pop_bus());
                mregs[mcmd[3:1]] = msh;
            end
        end
    end

    always @(negedge ds_sclk) begin
        if (ds_ce === 1'b1 && mread && ridx < 64) begin
            mio = mregs[3'(ridx / 8)][3'(ridx % 8)];
            ridx++;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) if (wr_ack === 1'b1) ack_cnt++;

    // CE-low gap between consecutive transactions
    logic        ce_prev = 1'b0;
    logic        gap_seen = 1'b0;
    int unsigned gap_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            gap_seen = 1'b0;
            gap_cnt  = 0;
        end else begin
            if (ds_ce === 1'b1 && !ce_prev && gap_seen) chk("ce_low_gap_ge8", 32'(gap_cnt >= 8), 1);
            if (ds_ce !== 1'b1 && ce_prev) begin
                gap_seen = 1'b1;
                gap_cnt  = 0;
            end
            if (ds_ce !== 1'b1) gap_cnt++;
        end
        ce_prev = (ds_ce === 1'b1);
    end

    function automatic logic sig(input int unsigned which);
        case (which)
            0: return ds_ce;
            1: return ds_sclk;
            2: return ds_io_oe;
            3: return wr_ack;
            default: return time_upd;
        endcase
    endfunction

    task automatic wait_level(input string tag, input int unsigned which, input logic lvl,
                              input int unsigned bound, output int unsigned n);
        n = 0;
        while (sig(which) !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sig(which) === lvl) else begin
            errors++;
            $error("FAIL %s: timeout after %0d cycles, observed %b expected %b", tag, n, sig(which), lvl);
        end
    endtask

    task automatic wait_upd(input string tag, input int unsigned bound);
        int unsigned n;
        logic [23:0] e;
        wait_level(tag, 4, 1'b1, bound, n);
        if (time_upd === 1'b1) begin
            e = exp_q.pop_front();
            chk({tag, "_sec"}, sec_bcd, e[7:0]);
            chk({tag, "_min"}, min_bcd, e[15:8]);
            chk({tag, "_hour"}, hour_bcd, e[23:16]);
            chk({tag, "_valid"}, time_valid, 1);
            chk({tag, "_busy_low"}, busy, 0);
            @(negedge clk);
            chk({tag, "_upd_pulse"}, time_upd, 0);
        end
    endtask

    initial begin
        int unsigned n;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mregs[0] = 8'h56;
        mregs[1] = 8'h34;
        mregs[2] = 8'h12;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ce", ds_ce, 0);
        chk("rst_sclk", ds_sclk, 0);
        chk("rst_io_out", ds_io_out, 0);
        chk("rst_io_oe", ds_io_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_time_upd", time_upd, 0);
        chk("rst_time_valid", time_valid, 0);
        chk("rst_sec", sec_bcd, 0);
        chk("rst_min", min_bcd, 0);
        chk("rst_hour", hour_bcd, 0);

        // first read: 12:34:56 plus bit-cell timing
        exp_q.push_back({8'h12, 8'h34, 8'h56});
        rst_n = 1'b1;
        wait_level("ce_rise", 0, 1'b1, 50, n);
        wait_level("sclk_rise0", 1, 1'b1, 100, n);
        chk("ce_to_sclk_rise", n, CE_SETUP + CLK_DIV);
        wait_level("sclk_fall0", 1, 1'b0, 100, n);
        chk("sclk_high_width", n, CLK_DIV);
        wait_level("sclk_rise1", 1, 1'b1, 100, n);
        chk("sclk_low_width", n, CLK_DIV);
        for (int i = 2; i < 8; i++) begin
            wait_level("sclk_fall", 1, 1'b0, 100, n);
            wait_level("sclk_rise", 1, 1'b1, 100, n);
        end
        wait_level("oe_fall", 2, 1'b0, 100, n);
        chk("oe_fall_delay", n, CLK_DIV);
        wait_upd("read1", 1000);

        // CH bit masked, 23h
        mregs[0] = 8'hD9;
        mregs[2] = 8'h23;
        exp_q.push_back({8'h23, 8'h34, 8'h59});
        wait_upd("ch_mask", 2500);

        // hour write then readback on next poll
        bus_q.push_back(8'h84);
        bus_q.push_back(8'h08);
        exp_q.push_back({8'h08, 8'h34, 8'h59});
        ack_cnt = 0;
        wr_addr = 5'd2;
        wr_data = 8'h08;
        wr_req  = 1'b1;
        wait_level("wr_ack1", 3, 1'b1, 1000, n);
        wr_req = 1'b0;
        wait_upd("write_readback", 2500);
        chk("wr_ack_count", ack_cnt, 1);

        // write request in the same cycle poll_pending sets
        bus_q.push_back(8'h84);
        bus_q.push_back(8'h15);
        exp_q.push_back({8'h15, 8'h34, 8'h59});
        n = 0;
        while (!((cyc % POLL) == 0 && cyc != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("poll_align_timeout", 32'(n < 5000), 1);
        wr_addr = 5'd2;
        wr_data = 8'h15;
        wr_req  = 1'b1;
        @(negedge clk);
        chk("tie_busy", busy, 1);
        chk("tie_write_first", ds_io_out, 0);
        wait_level("wr_ack2", 3, 1'b1, 1000, n);
        wr_req = 1'b0;
        wait_upd("tie_readback", 400);

        // reset during read bit 12
        wait_level("ce_rise_r", 0, 1'b1, 3000, n);
        for (int i = 0; i < 12; i++) begin
            wait_level("sclk_rise_r", 1, 1'b1, 100, n);
            wait_level("sclk_fall_r", 1, 1'b0, 100, n);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ce", ds_ce, 0);
        chk("midrst_sclk", ds_sclk, 0);
        chk("midrst_oe", ds_io_oe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sec", sec_bcd, 0);
        chk("midrst_min", min_bcd, 0);
        chk("midrst_hour", hour_bcd, 0);
        chk("midrst_valid", time_valid, 0);
        mregs[0] = 8'h07;
        mregs[1] = 8'h45;
        mregs[2] = 8'h21;
        exp_q.push_back({8'h21, 8'h45, 8'h07});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_upd("post_reset", 600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
